// File: rtl/audio_sample_sequencer.sv
// Codec-to-DSP sample sequencer: read, process (or bypass), write one stereo pair at a time.
// Optional AUDIO_SEQ_ATTEN_EN adds an atten input that arithmetic-shifts every written pair.
module audio_sample_sequencer #(
    parameter int DW          = 24,
    parameter int TIMEOUT_CYC = 1024,
    parameter int CNT_W       = 16
) (
    input  logic             CLOCK_50,
    input  logic             reset_n,
    input  logic             bypass,
    input  logic             read_ready,
    input  logic [DW-1:0]    readdata_left,
    input  logic [DW-1:0]    readdata_right,
    output logic             read,
    input  logic             write_ready,
    output logic             write,
    output logic [DW-1:0]    writedata_left,
    output logic [DW-1:0]    writedata_right,
    output logic             proc_valid,
    input  logic             proc_ready,
    output logic [DW-1:0]    proc_left,
    output logic [DW-1:0]    proc_right,
    input  logic             result_valid,
    input  logic [DW-1:0]    result_left,
    input  logic [DW-1:0]    result_right,
    output logic             sample_done,
`ifdef AUDIO_SEQ_ATTEN_EN
    input  logic [3:0]       atten,
`endif
    output logic [CNT_W-1:0] timeout_count
);

    localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE,
        PROC,
        WAIT,
        WRITE
    } state_t;

    state_t state, state_d;

    logic             read_d, write_d, done_d, pv_d;
    logic [DW-1:0]    pl_d, pr_d, wl_d, wr_d;
    logic [DW-1:0]    last_l, last_r, last_l_d, last_r_d;
    logic [TW-1:0]    timer, timer_d;
    logic [CNT_W-1:0] cnt_d;
    logic             expired;

    function automatic logic [DW-1:0] scale(input logic [DW-1:0] x);
`ifdef AUDIO_SEQ_ATTEN_EN
        scale = DW'($signed(x) >>> atten);
`else
        scale = x;
`endif
    endfunction

    assign expired = (timer == TMAX);

    always_comb begin
        state_d  = state;
        read_d   = 1'b0;
        write_d  = 1'b0;
        done_d   = 1'b0;
        pv_d     = proc_valid;
        pl_d     = proc_left;
        pr_d     = proc_right;
        wl_d     = writedata_left;
        wr_d     = writedata_right;
        last_l_d = last_l;
        last_r_d = last_r;
        timer_d  = timer;
        cnt_d    = timeout_count;
        unique case (state)
            IDLE: begin
                if (read_ready) begin
                    read_d = 1'b1;
                    pl_d   = readdata_left;
                    pr_d   = readdata_right;
                    if (bypass) begin
                        wl_d    = scale(readdata_left);
                        wr_d    = scale(readdata_right);
                        state_d = WRITE;
                    end else begin
                        timer_d = '0;
                        pv_d    = 1'b1;
                        state_d = PROC;
                    end
                end
            end
            PROC: begin
                timer_d = timer + 1'b1;
                // A DSP that never accepts still has to be bounded.
                if (expired) begin
                    pv_d    = 1'b0;
                    wl_d    = scale(last_l);
                    wr_d    = scale(last_r);
                    cnt_d   = (&timeout_count) ? timeout_count
                                               : timeout_count + 1'b1;
                    state_d = WRITE;
                end else if (proc_ready) begin
                    pv_d    = 1'b0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                timer_d = timer + 1'b1;
                if (result_valid) begin
                    wl_d    = scale(result_left);
                    wr_d    = scale(result_right);
                    state_d = WRITE;
                end else if (expired) begin
                    wl_d    = scale(last_l);
                    wr_d    = scale(last_r);
                    cnt_d   = (&timeout_count) ? timeout_count
                                               : timeout_count + 1'b1;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (write_ready) begin
                    write_d  = 1'b1;
                    done_d   = 1'b1;
                    last_l_d = writedata_left;
                    last_r_d = writedata_right;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            read            <= 1'b0;
            write           <= 1'b0;
            sample_done     <= 1'b0;
            proc_valid      <= 1'b0;
            proc_left       <= '0;
            proc_right      <= '0;
            writedata_left  <= '0;
            writedata_right <= '0;
            last_l          <= '0;
            last_r          <= '0;
            timer           <= '0;
            timeout_count   <= '0;
        end else begin
            state           <= state_d;
            read            <= read_d;
            write           <= write_d;
            sample_done     <= done_d;
            proc_valid      <= pv_d;
            proc_left       <= pl_d;
            proc_right      <= pr_d;
            writedata_left  <= wl_d;
            writedata_right <= wr_d;
            last_l          <= last_l_d;
            last_r          <= last_r_d;
            timer           <= timer_d;
            timeout_count   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_audio_sample_sequencer.sv
// Randomized transaction bench for audio_sample_sequencer with a pair-level reference model.
// Model tracks last-written pair and saturating timeout count from the sequencing rules.
module tb_audio_sample_sequencer;

    localparam int DW = 24;
    localparam int TO = 8;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          bypass, read_ready, write_ready;
    logic          proc_ready, result_valid;
    logic [DW-1:0] rdl, rdr, rsl, rsr;
    logic          read, write, proc_valid, sample_done;
    logic [DW-1:0] wdl, wdr, pl, pr;
    logic [CW-1:0] tcount;
`ifdef AUDIO_SEQ_ATTEN_EN
    logic [3:0]    atten = 4'd0;
`endif

    int checks   = 0;
    int failures = 0;
    logic [2*DW-1:0] last_m;
    int unsigned     cnt_m;

    always #5 clk = ~clk;

    audio_sample_sequencer #(
        .DW(DW), .TIMEOUT_CYC(TO), .CNT_W(CW)
    ) dut (
        .CLOCK_50       (clk),
        .reset_n        (rst_n),
        .bypass         (bypass),
        .read_ready     (read_ready),
        .readdata_left  (rdl),
        .readdata_right (rdr),
        .read           (read),
        .write_ready    (write_ready),
        .write          (write),
        .writedata_left (wdl),
        .writedata_right(wdr),
        .proc_valid     (proc_valid),
        .proc_ready     (proc_ready),
        .proc_left      (pl),
        .proc_right     (pr),
        .result_valid   (result_valid),
        .result_left    (rsl),
        .result_right   (rsr),
        .sample_done    (sample_done),
`ifdef AUDIO_SEQ_ATTEN_EN
        .atten          (atten),
`endif
        .timeout_count  (tcount)
    );

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // pd/rk: cycle offsets from PROC entry for proc_ready/result_valid (-1 = never)
    task automatic do_pair(input string tg, input bit byp,
                           input logic [DW-1:0] l, input logic [DW-1:0] r,
                           input int pd, input int rk,
                           input logic [DW-1:0] res_l, input logic [DW-1:0] res_r,
                           input bit stray, input int wd);
        logic [2*DW-1:0] expw;
        logic [DW-1:0]   dl, dr;
        bit              in_wait, done, tout;
        bypass     = byp;
        rdl        = l;
        rdr        = r;
        read_ready = 1'b1;
        tick();
        check({tg, ":read"}, 64'(read), 64'd1);
        check({tg, ":held"}, 64'({pl, pr}), 64'({l, r}));
        check({tg, ":pv0"}, 64'(proc_valid), 64'(!byp));
        read_ready = 1'b0;
        rdl        = DW'($urandom());
        rdr        = DW'($urandom());
        bypass     = 1'($urandom());
        tout       = 1'b0;
        expw       = {l, r};
        if (!byp) begin
            in_wait = 1'b0;
            done    = 1'b0;
            for (int k = 0; k < TO && !done; k++) begin
                proc_ready   = (k == pd);
                dl           = (k == rk) ? res_l : DW'($urandom());
                dr           = (k == rk) ? res_r : DW'($urandom());
                rsl          = dl;
                rsr          = dr;
                result_valid = (k == rk) || (stray && !in_wait);
                if (in_wait && result_valid) begin
                    expw = {dl, dr};
                    done = 1'b1;
                end else if (k == TO - 1) begin
                    expw = last_m;
                    tout = 1'b1;
                    done = 1'b1;
                end else if (!in_wait && proc_ready) begin
                    in_wait = 1'b1;
                end
                tick();
                check({tg, ":noread"}, 64'(read), 64'd0);
                check({tg, ":pv"}, 64'(proc_valid), 64'(!done && !in_wait));
                check({tg, ":pstable"}, 64'({pl, pr}), 64'({l, r}));
            end
            proc_ready   = 1'b0;
            result_valid = 1'b0;
        end
        if (tout) cnt_m = (cnt_m == 3) ? 3 : cnt_m + 1;
        read_ready = (wd > 0);
        for (int i = 0; i < wd; i++) begin
            write_ready = 1'b0;
            tick();
            check({tg, ":bp_write"}, 64'(write), 64'd0);
            check({tg, ":bp_read"}, 64'(read), 64'd0);
            check({tg, ":bp_data"}, 64'({wdl, wdr}), 64'(expw));
        end
        read_ready  = 1'b0;
        write_ready = 1'b1;
        tick();
        check({tg, ":write"}, 64'(write), 64'd1);
        check({tg, ":done"}, 64'(sample_done), 64'd1);
        check({tg, ":wdata"}, 64'({wdl, wdr}), 64'(expw));
        check({tg, ":tcount"}, 64'(tcount), 64'(cnt_m));
        check({tg, ":wr_noread"}, 64'(read), 64'd0);
        write_ready = 1'($urandom());
        tick();
        check({tg, ":write_end"}, 64'(write), 64'd0);
        check({tg, ":done_end"}, 64'(sample_done), 64'd0);
        check({tg, ":data_hold"}, 64'({wdl, wdr}), 64'(expw));
        write_ready = 1'b0;
        last_m      = expw;
    endtask

    task automatic check_zero(input string tg);
        check({tg, ":read"}, 64'(read), 64'd0);
        check({tg, ":write"}, 64'(write), 64'd0);
        check({tg, ":pv"}, 64'(proc_valid), 64'd0);
        check({tg, ":done"}, 64'(sample_done), 64'd0);
        check({tg, ":wdata"}, 64'({wdl, wdr}), 64'd0);
        check({tg, ":pdata"}, 64'({pl, pr}), 64'd0);
        check({tg, ":tcount"}, 64'(tcount), 64'd0);
    endtask

    initial begin
        int pd, rk, wd;
        rst_n        = 1'b0;
        bypass       = 1'b0;
        read_ready   = 1'b0;
        write_ready  = 1'b0;
        proc_ready   = 1'b0;
        result_valid = 1'b0;
        rdl = '0; rdr = '0; rsl = '0; rsr = '0;
        last_m = '0;
        cnt_m  = 0;
        repeat (3) tick();
        check_zero("reset");
        rst_n = 1'b1;
        tick();
        check_zero("post_reset");

        do_pair("bypass", 1'b1, 24'h123456, 24'hFEDCBA, -1, -1, '0, '0, 1'b0, 0);
        do_pair("dsp", 1'b0, 24'h0ABCDE, 24'h111111, 3, 5,
                24'h000010, 24'hFFFFF0, 1'b1, 0);
        do_pair("tout_wait", 1'b0, 24'h222222, 24'h333333, 1, -1, '0, '0, 1'b0, 0);
        do_pair("tout_race", 1'b0, 24'h444444, 24'h555555, 2, TO - 1,
                24'h0000AA, 24'h0000BB, 1'b0, 0);
        do_pair("tout_proc", 1'b0, 24'h666666, 24'h777777, -1, -1, '0, '0, 1'b1, 0);
        do_pair("backpress", 1'b1, 24'h888888, 24'h999999, -1, -1, '0, '0, 1'b0, 20);
        do_pair("sat_a", 1'b0, 24'hAAAAAA, 24'hBBBBBB, 0, -1, '0, '0, 1'b0, 1);
        do_pair("sat_b", 1'b0, 24'hCCCCCC, 24'hDDDDDD, 0, -1, '0, '0, 1'b0, 2);

        for (int n = 0; n < 40; n++) begin
            pd = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, 5));
            rk = ($urandom_range(0, 4) == 0) ? -1 : pd + int'($urandom_range(1, 4));
            wd = int'($urandom_range(0, 3));
            do_pair("rand", 1'($urandom()), DW'($urandom()), DW'($urandom()),
                    pd, rk, DW'($urandom()), DW'($urandom()),
                    1'($urandom()), wd);
        end

        bypass     = 1'b0;
        rdl        = 24'h5A5A5A;
        rdr        = 24'hA5A5A5;
        read_ready = 1'b1;
        tick();
        read_ready = 1'b0;
        proc_ready = 1'b1;
        tick();
        proc_ready = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        check_zero("mid_reset");
        tick();
        rst_n       = 1'b1;
        write_ready = 1'b1;
        for (int i = 0; i < TO + 4; i++) begin
            tick();
            check("after_reset:write", 64'(write), 64'd0);
            check("after_reset:read", 64'(read), 64'd0);
            check("after_reset:pv", 64'(proc_valid), 64'd0);
        end
        write_ready = 1'b0;
        last_m      = '0;
        cnt_m       = 0;
        do_pair("recover_tout", 1'b0, 24'h010203, 24'h040506, 0, -1, '0, '0, 1'b0, 0);
        do_pair("recover_byp", 1'b1, 24'h7FFFFF, 24'h800000, -1, -1, '0, '0, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
